wave_sel_scheduler: RTL and testbench
=====================================

WAVE_SEL_SCHEDULER -- requirements
Module: wave_sel_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_WAVES, default 5, giving the number of selectable waveforms (codes 0..NUM_WAVES-1: sine, square, triangle, sawtooth, ECG).
REQ-002 The module SHALL have parameter BLANK_CYCLES, default 4, giving the output-blank duration in clocks after each switch (minimum 1).
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 65535, giving the maximum wait for period_tick before a forced switch.
REQ-004 The module SHALL have port clk, input, width 1: the single clock. Clock is one clock; reset is synchronous and active-high.
REQ-005 The module SHALL have port rst, input, width 1: synchronous active-high reset.
REQ-006 The module SHALL have port btn_next, input, width 1: one-clock debounced pulse requesting the next waveform.
REQ-007 The module SHALL have port noise_btn, input, width 1: one-clock pulse toggling noise.
REQ-008 The module SHALL have port period_tick, input, width 1: one-clock pulse at each generator phase wrap.
REQ-009 The module SHALL have port auto_en, input, width 1: enables automatic scanning.
REQ-010 The module SHALL have port dwell_periods, input, width 8: periods per waveform in auto mode (value 0 treated as 1).
REQ-011 The module SHALL have port wave_sel, output, width 3: waveform select to the mux.
REQ-012 The module SHALL have port noise_en, output, width 1: noise add enable to the mux.
REQ-013 The module SHALL have port blank, output, width 1: downstream forces sample to 0 while high.
REQ-014 The module SHALL have port busy, output, width 1: high in PENDING or BLANK.

Function
REQ-015 The FSM SHALL have states HOLD, PENDING and BLANK; all outputs SHALL be registered.
REQ-016 In HOLD, btn_next=1 SHALL move the FSM to PENDING on the next edge, and busy SHALL rise that edge.
REQ-017 In PENDING, period_tick=1 SHALL advance wave_sel on the next edge (NUM_WAVES-1 wraps to 0), move the FSM to BLANK, and set blank=1 in the same edge.
REQ-018 In PENDING, a wait counter SHALL increment each clock; when it reaches TIMEOUT_CYCLES without period_tick, the switch SHALL occur exactly as in REQ-017.
REQ-019 BLANK SHALL last exactly BLANK_CYCLES clocks, after which the FSM returns to HOLD with blank=0 and busy=0 on the same edge.
REQ-020 btn_next in PENDING or BLANK SHALL be ignored and not queued.
REQ-021 btn_next and period_tick together in HOLD SHALL go to PENDING; that tick SHALL NOT complete the switch.
REQ-022 noise_btn SHALL toggle noise_en on the next edge in any state, independent of the FSM.
REQ-023 wave_sel SHALL change only on entry to BLANK and never holds a value at or above NUM_WAVES.

Reset
REQ-024 rst=1 at a clock edge SHALL force the FSM to HOLD with wave_sel=0, noise_en=0, blank=0, busy=0, and the dwell and wait counters at 0, overriding all other inputs, including mid-PENDING or mid-BLANK.

Configuration
REQ-025 With macro WAVE_AUTO_SCAN_EN defined, in HOLD with auto_en=1, each period_tick SHALL increment an 8-bit dwell counter; the tick on which the count reaches max(dwell_periods,1) SHALL switch directly as in REQ-017, without PENDING, and clear the counter.
REQ-026 With WAVE_AUTO_SCAN_EN defined, the dwell counter SHALL clear on any switch, on auto_en=0, and on reset; btn_next and dwell expiry in the same cycle SHALL take the btn path only, giving one advance.
REQ-027 Without WAVE_AUTO_SCAN_EN, auto_en and dwell_periods SHALL be ignored and no dwell counter SHALL exist.

Verification
REQ-028 Reset, then btn_next at cycle 10 and period_tick at cycle 20 -> busy=1 from cycle 11; wave_sel 0->1 and blank=1 at cycle 21; blank=0 and busy=0 at cycle 25.
REQ-029 Press btn_next 5 times, each followed by a tick -> wave_sel sequence 1,2,3,4,0.
REQ-030 btn_next with no period_tick -> forced switch exactly TIMEOUT_CYCLES clocks after PENDING entry.
REQ-031 Assert rst during BLANK, and pulse btn_next during PENDING -> all outputs reset and the extra pulse is ignored; noise_btn x3 -> noise_en toggles 1,0,1.
REQ-032 With WAVE_AUTO_SCAN_EN defined, auto_en=1 and dwell_periods=3 -> wave_sel advances on every 3rd tick; dwell_periods=0 -> advances every tick.

Source files
------------

// File: rtl/wave_sel_scheduler.sv
// Waveform-select scheduler: defers each switch to a generator phase wrap, then blanks the output briefly.
// Optional automatic scanning is compiled in with the WAVE_AUTO_SCAN_EN macro.
module wave_sel_scheduler #(
  parameter int NUM_WAVES      = 5,
  parameter int BLANK_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       noise_btn,
  input  logic       period_tick,
  input  logic       auto_en,
  input  logic [7:0] dwell_periods,
  output logic [2:0] wave_sel,
  output logic       noise_en,
  output logic       blank,
  output logic       busy
);

  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_PENDING = 2'd1;
  localparam logic [1:0] S_BLANK   = 2'd2;

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BLK_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]        WAVE_LAST = 3'(NUM_WAVES - 1);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BLK_W-1:0]  blank_cnt;
  logic              dwell_hit;

  // The >= keeps wave_sel in range even if it were ever loaded out of range.
  function automatic logic [2:0] next_wave(input logic [2:0] w);
    return (w >= WAVE_LAST) ? 3'd0 : w + 3'd1;
  endfunction

`ifdef WAVE_AUTO_SCAN_EN
  logic [7:0] dwell_cnt;
  logic [7:0] dwell_eff;

  // A pending btn_next wins over dwell expiry so only one advance happens.
  always_comb begin
    dwell_eff = (dwell_periods == 8'd0) ? 8'd1 : dwell_periods;
    dwell_hit = (state == S_HOLD) && auto_en && period_tick && !btn_next &&
                (({1'b0, dwell_cnt} + 9'd1) >= {1'b0, dwell_eff});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt <= 8'd0;
    end else if (!auto_en || state != S_HOLD || btn_next || dwell_hit) begin
      dwell_cnt <= 8'd0;
    end else if (period_tick) begin
      dwell_cnt <= dwell_cnt + 8'd1;
    end
  end
`else
  logic unused_auto;
  assign dwell_hit   = 1'b0;
  assign unused_auto = ^{auto_en, dwell_periods};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HOLD;
      wave_sel  <= 3'd0;
      blank     <= 1'b0;
      busy      <= 1'b0;
      wait_cnt  <= '0;
      blank_cnt <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (btn_next) begin
            state    <= S_PENDING;
            busy     <= 1'b1;
            wait_cnt <= '0;
          end else if (dwell_hit) begin
            state     <= S_BLANK;
            wave_sel  <= next_wave(wave_sel);
            blank     <= 1'b1;
            busy      <= 1'b1;
            blank_cnt <= '0;
          end
        end
        S_PENDING: begin
          // wait_cnt reads k-1 on the k-th edge after entry, so the forced switch lands on edge TIMEOUT_CYCLES.
          if (period_tick || wait_cnt == WAIT_LAST) begin
            state     <= S_BLANK;
            wave_sel  <= next_wave(wave_sel);
            blank     <= 1'b1;
            blank_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_BLANK: begin
          if (blank_cnt == BLK_LAST) begin
            state <= S_HOLD;
            blank <= 1'b0;
            busy  <= 1'b0;
          end else begin
            blank_cnt <= blank_cnt + BLK_W'(1);
          end
        end
        default: begin
          state <= S_HOLD;
          blank <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      noise_en <= 1'b0;
    end else if (noise_btn) begin
      noise_en <= ~noise_en;
    end
  end

endmodule

// File: tb/tb_wave_sel_scheduler.sv
// Scoreboard bench for wave_sel_scheduler: stimulus queues expected output changes, a monitor checks them.
module tb_wave_sel_scheduler;
  localparam int NW = 5;
  localparam int BC = 4;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_next = 1'b0;
  logic       noise_btn = 1'b0;
  logic       period_tick = 1'b0;
  logic       auto_en = 1'b0;
  logic [7:0] dwell_periods = 8'd0;
  logic [2:0] wave_sel;
  logic       noise_en;
  logic       blank;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    int         cyc;
    logic [5:0] out;
  } ev_t;

  ev_t        q[$];
  logic [5:0] prev;
  bit         mon_en = 1'b0;

  wave_sel_scheduler #(.NUM_WAVES(NW), .BLANK_CYCLES(BC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .noise_btn(noise_btn),
    .period_tick(period_tick), .auto_en(auto_en), .dwell_periods(dwell_periods),
    .wave_sel(wave_sel), .noise_en(noise_en), .blank(blank), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output change: output vector is {wave_sel, noise_en, blank, busy}.
  task automatic expect_ev(input int c, input logic [2:0] w, input logic nz, input logic bl, input logic bs);
    ev_t e;
    e.cyc = c;
    e.out = {w, nz, bl, bs};
    q.push_back(e);
  endtask

  task automatic at(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [5:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = {wave_sel, noise_en, blank, busy};
      if (cur !== prev) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change cyc=%0d got=%b required=no change from %b", cyc, cur, prev);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.out !== cur) begin
            bad++;
            $display("FAIL out_event got cyc=%0d out=%b required cyc=%0d out=%b", cyc, cur, e.cyc, e.out);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held over edges 1..3.
    at(3);
    total++;
    if ({wave_sel, noise_en, blank, busy} !== 6'b0) begin
      bad++;
      $display("FAIL reset_state got=%b required=000000", {wave_sel, noise_en, blank, busy});
    end
    rst  = 1'b0;
    prev = {wave_sel, noise_en, blank, busy};
    mon_en = 1'b1;

    // Basic switch; btn pulses in PENDING and BLANK are ignored.
    at(10); btn_next = 1'b1; expect_ev(11, 3'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0;
    at(15); btn_next = 1'b1; @(negedge clk); btn_next = 1'b0;
    at(20); period_tick = 1'b1;
    expect_ev(21, 3'd1, 1'b0, 1'b1, 1'b1);
    expect_ev(25, 3'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    at(22); btn_next = 1'b1; @(negedge clk); btn_next = 1'b0;

    // Five presses with simultaneous btn+tick in HOLD: 2,3,4,0,1.
    at(30); btn_next = 1'b1; period_tick = 1'b1; expect_ev(31, 3'd1, 1'b0, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0; period_tick = 1'b0;
    at(33); period_tick = 1'b1; expect_ev(34, 3'd2, 1'b0, 1'b1, 1'b1); expect_ev(38, 3'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    at(40); btn_next = 1'b1; period_tick = 1'b1; expect_ev(41, 3'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0; period_tick = 1'b0;
    at(43); period_tick = 1'b1; expect_ev(44, 3'd3, 1'b0, 1'b1, 1'b1); expect_ev(48, 3'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    at(50); btn_next = 1'b1; period_tick = 1'b1; expect_ev(51, 3'd3, 1'b0, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0; period_tick = 1'b0;
    at(53); period_tick = 1'b1; expect_ev(54, 3'd4, 1'b0, 1'b1, 1'b1); expect_ev(58, 3'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    at(60); btn_next = 1'b1; period_tick = 1'b1; expect_ev(61, 3'd4, 1'b0, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0; period_tick = 1'b0;
    at(63); period_tick = 1'b1; expect_ev(64, 3'd0, 1'b0, 1'b1, 1'b1); expect_ev(68, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    at(70); btn_next = 1'b1; period_tick = 1'b1; expect_ev(71, 3'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0; period_tick = 1'b0;
    at(73); period_tick = 1'b1; expect_ev(74, 3'd1, 1'b0, 1'b1, 1'b1); expect_ev(78, 3'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;

    // Forced switch TO clocks after PENDING entry at edge 81.
    at(80); btn_next = 1'b1; expect_ev(81, 3'd1, 1'b0, 1'b0, 1'b1);
    expect_ev(81 + TO, 3'd2, 1'b0, 1'b1, 1'b1); expect_ev(85 + TO, 3'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk); btn_next = 1'b0;

    // Reset mid-PENDING overrides a coincident tick.
    at(130); btn_next = 1'b1; expect_ev(131, 3'd2, 1'b0, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0;
    at(132); rst = 1'b1; period_tick = 1'b1; expect_ev(133, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0; period_tick = 1'b0;

    // Reset mid-BLANK also clears noise_en and swallows a coincident btn.
    at(140); noise_btn = 1'b1; expect_ev(141, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); noise_btn = 1'b0;
    at(150); btn_next = 1'b1; expect_ev(151, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0;
    at(152); btn_next = 1'b1; @(negedge clk); btn_next = 1'b0;
    at(153); period_tick = 1'b1; expect_ev(154, 3'd1, 1'b1, 1'b1, 1'b1);
    @(negedge clk); period_tick = 1'b0;
    at(155); rst = 1'b1; btn_next = 1'b1; expect_ev(156, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0; btn_next = 1'b0;

    // noise_btn x3 across HOLD, PENDING and BLANK: 1,0,1.
    at(160); noise_btn = 1'b1; expect_ev(161, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); noise_btn = 1'b0;
    at(163); btn_next = 1'b1; expect_ev(164, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0;
    at(166); noise_btn = 1'b1; expect_ev(167, 3'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk); noise_btn = 1'b0;
    at(168); period_tick = 1'b1; expect_ev(169, 3'd1, 1'b0, 1'b1, 1'b1);
    @(negedge clk); period_tick = 1'b0;
    at(170); noise_btn = 1'b1; expect_ev(171, 3'd1, 1'b1, 1'b1, 1'b1); expect_ev(173, 3'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); noise_btn = 1'b0;

`ifdef WAVE_AUTO_SCAN_EN
    // dwell=3: switch on the third tick.
    at(180); auto_en = 1'b1; dwell_periods = 8'd3;
    for (int i = 0; i < 3; i++) begin
      at(180 + 6 * i); period_tick = 1'b1;
      if (i == 2) begin
        expect_ev(193, 3'd2, 1'b1, 1'b1, 1'b1); expect_ev(197, 3'd2, 1'b1, 1'b0, 1'b0);
      end
      @(negedge clk); period_tick = 1'b0;
    end
    // dwell=0 behaves as 1: every tick switches (3,4,0).
    at(200); dwell_periods = 8'd0;
    period_tick = 1'b1; expect_ev(201, 3'd3, 1'b1, 1'b1, 1'b1); expect_ev(205, 3'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    at(210); period_tick = 1'b1; expect_ev(211, 3'd4, 1'b1, 1'b1, 1'b1); expect_ev(215, 3'd4, 1'b1, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    at(220); period_tick = 1'b1; expect_ev(221, 3'd0, 1'b1, 1'b1, 1'b1); expect_ev(225, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    // btn and dwell expiry together: btn path only, one advance.
    at(230); btn_next = 1'b1; period_tick = 1'b1; expect_ev(231, 3'd0, 1'b1, 1'b0, 1'b1);
    @(negedge clk); btn_next = 1'b0; period_tick = 1'b0;
    at(233); period_tick = 1'b1; expect_ev(234, 3'd1, 1'b1, 1'b1, 1'b1); expect_ev(238, 3'd1, 1'b1, 1'b0, 1'b0);
    @(negedge clk); period_tick = 1'b0;
    at(240); auto_en = 1'b0;
`else
    // Auto scanning absent: ticks with auto_en=1 change nothing.
    at(180); auto_en = 1'b1; dwell_periods = 8'd1;
    for (int i = 0; i < 8; i++) begin
      at(180 + 6 * i); period_tick = 1'b1;
      @(negedge clk); period_tick = 1'b0;
    end
    at(240); auto_en = 1'b0;
`endif

    at(260);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL pending_events got=%0d left required=0 (next cyc=%0d)", q.size(), q[0].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
